mem_arbiter: RTL and testbench

Two-port arbiter sharing one single-ported instruction/data memory between the icache refill port and the processor data port. It sits between the icache's `mem_req_*` interface, the processor's data-side valid/ready bus and a unified memory, and lets one memory image back both streams. Transactions are non-overlapping and complete in full once granted. Port selection is round-robin, or fixed data-first when configured.

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between the icache refill port and the data port.
// Optional grant/conflict statistics ports are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_gnt_i,
  output logic [31:0] stat_gnt_d,
  output logic [31:0] stat_conflict
`endif
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_last_d;
  logic            w_d_wins_tie;
  logic            w_enter_i;
  logic            w_enter_d;
  logic            r_mem_valid;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [SW-1:0]   r_mem_wstrb;

  // Next-state selection and combinational completion pulses
  always_comb begin
    w_state_next = r_state;
    w_d_wins_tie = (FIXED_PRIO != 32'd0) || !r_last_d;
    w_enter_i    = 1'b0;
    w_enter_d    = 1'b0;
    i_ready      = 1'b0;
    d_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_valid && (!i_valid || w_d_wins_tie)) begin
          w_state_next = GNT_D;
          w_enter_d    = 1'b1;
        end else if (i_valid) begin
          w_state_next = GNT_I;
          w_enter_i    = 1'b1;
        end
      end
      GNT_I: begin
        i_ready = mem_ready;
        if (mem_ready) w_state_next = IDLE;
      end
      GNT_D: begin
        d_ready = mem_ready;
        if (mem_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, last-grant tracking and the request captured at grant entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mem_valid <= (w_state_next != IDLE);
      if (w_enter_i) begin
        r_last_d    <= 1'b0;
        r_mem_addr  <= i_addr;
        r_mem_wdata <= '0;
        r_mem_wstrb <= '0;
      end else if (w_enter_d) begin
        r_last_d    <= 1'b1;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
        r_mem_wstrb <= d_wstrb;
      end
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

`ifdef MEM_ARB_STATS_EN
  localparam int unsigned CW = 32;

  logic [CW-1:0] r_stat_gnt_i;
  logic [CW-1:0] r_stat_gnt_d;
  logic [CW-1:0] r_stat_conflict;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_gnt_i    <= '0;
      r_stat_gnt_d    <= '0;
      r_stat_conflict <= '0;
    end else begin
      if (w_enter_i && (r_stat_gnt_i != '1)) r_stat_gnt_i <= r_stat_gnt_i + CW'(1);
      if (w_enter_d && (r_stat_gnt_d != '1)) r_stat_gnt_d <= r_stat_gnt_d + CW'(1);
      if ((r_state == IDLE) && i_valid && d_valid && (r_stat_conflict != '1))
        r_stat_conflict <= r_stat_conflict + CW'(1);
    end
  end

  assign stat_gnt_i    = r_stat_gnt_i;
  assign stat_gnt_d    = r_stat_gnt_d;
  assign stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 round-robin, instance 1 fixed data-first.
// A transaction-level model is compared every cycle; directed phases add literal expectations.
module tb_mem_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset     [2];
  logic        i_valid   [2];
  logic        i_ready   [2];
  logic [31:0] i_addr    [2];
  logic [31:0] i_rdata   [2];
  logic        d_valid   [2];
  logic        d_ready   [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic [3:0]  d_wstrb   [2];
  logic [31:0] d_rdata   [2];
  logic        mem_valid [2];
  logic        mem_ready [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_wstrb [2];
  logic [31:0] mem_rdata [2];
`ifdef MEM_ARB_STATS_EN
  logic [31:0] st_i [2];
  logic [31:0] st_d [2];
  logic [31:0] st_c [2];
`endif

  mem_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(reset[0]),
    .i_valid(i_valid[0]), .i_ready(i_ready[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]),
    .d_valid(d_valid[0]), .d_ready(d_ready[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_wstrb(d_wstrb[0]), .d_rdata(d_rdata[0]),
    .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .mem_rdata(mem_rdata[0])
`ifdef MEM_ARB_STATS_EN
    , .stat_gnt_i(st_i[0]), .stat_gnt_d(st_d[0]), .stat_conflict(st_c[0])
`endif
  );

  mem_arbiter #(.FIXED_PRIO(1)) u_fx (
    .clk(clk), .reset(reset[1]),
    .i_valid(i_valid[1]), .i_ready(i_ready[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]),
    .d_valid(d_valid[1]), .d_ready(d_ready[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_wstrb(d_wstrb[1]), .d_rdata(d_rdata[1]),
    .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .mem_rdata(mem_rdata[1])
`ifdef MEM_ARB_STATS_EN
    , .stat_gnt_i(st_i[1]), .stat_gnt_d(st_d[1]), .stat_conflict(st_c[1])
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  txn_t        qi [2][$];
  txn_t        qd [2][$];
  logic [31:0] mem [bit [32:0]];
  int          wait_c [2];
  int          cnt    [2];
  bit          spur   [2];
  bit          hs_i   [2];
  bit          hs_d   [2];

  int          obs     [2][$];
  int          obs_cyc [2][$];
  int          vst_cyc [2][$];
  logic        prev_mv [2];
  logic [31:0] cap_i_rdata [2];
  logic [31:0] cap_i_addr  [2];
  logic [3:0]  cap_i_wstrb [2];
  logic [31:0] cap_d_addr  [2];
  logic [31:0] cap_d_wdata [2];
  logic [3:0]  cap_d_wstrb [2];

  // Model: owner 0 = none, 1 = icache, 2 = data
  bit          mv     [2];
  int          m_own  [2];
  int          m_last [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [3:0]  m_wstrb[2];
  int          m_si [2];
  int          m_sd [2];
  int          m_sc [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [31:0] rd(input int k, input logic [31:0] a);
    bit [32:0] key = {1'(k), a};
    if (mem.exists(key)) return mem[key];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic wr(input int k, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] v = rd(k, a);
    for (int b = 0; b < 4; b++) if (st[b]) v[8*b +: 8] = wd[8*b +: 8];
    mem[{1'(k), a}] = v;
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    txn_t t;
    t.addr = a; t.wdata = wd; t.wstrb = st;
    return t;
  endfunction

  // Memory responders and requesters, driven just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        txn_t t;
        if (mem_valid[k] === 1'b1) begin
          if (cnt[k] == wait_c[k]) begin
            mem_ready[k] = 1'b1;
            mem_rdata[k] = rd(k, mem_addr[k]);
            if (mem_wstrb[k] != 4'd0) wr(k, mem_addr[k], mem_wdata[k], mem_wstrb[k]);
          end else begin
            mem_ready[k] = 1'b0;
          end
          cnt[k]++;
        end else begin
          cnt[k]       = 0;
          mem_ready[k] = spur[k];
          spur[k]      = 1'b0;
          mem_rdata[k] = 32'hBAD0_0000 | 32'(cyc);
        end
        if (hs_i[k]) begin i_valid[k] = 1'b0; hs_i[k] = 1'b0; end
        if (!i_valid[k] && qi[k].size() > 0) begin
          t = qi[k].pop_front();
          i_addr[k] = t.addr; i_valid[k] = 1'b1;
        end
        if (hs_d[k]) begin d_valid[k] = 1'b0; hs_d[k] = 1'b0; end
        if (!d_valid[k] && qd[k].size() > 0) begin
          t = qd[k].pop_front();
          d_addr[k] = t.addr; d_wdata[k] = t.wdata; d_wstrb[k] = t.wstrb; d_valid[k] = 1'b1;
        end
      end
    end
  end

  // Compare process: check against the model mid-cycle, log observations, then advance the model
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        int  w;
        bit  exp_i, exp_d;
        exp_i = (m_own[k] == 1) && (mem_ready[k] === 1'b1);
        exp_d = (m_own[k] == 2) && (mem_ready[k] === 1'b1);
        if (mv[k]) begin
          check($sformatf("mem_valid[%0d]", k), 32'(mem_valid[k]), 32'(m_own[k] != 0));
          check($sformatf("mem_addr[%0d]", k), mem_addr[k], m_addr[k]);
          check($sformatf("mem_wstrb[%0d]", k), 32'(mem_wstrb[k]), 32'(m_wstrb[k]));
          if (m_own[k] == 2) check($sformatf("mem_wdata[%0d]", k), mem_wdata[k], m_wdata[k]);
          check($sformatf("i_ready[%0d]", k), 32'(i_ready[k]), 32'(exp_i));
          check($sformatf("d_ready[%0d]", k), 32'(d_ready[k]), 32'(exp_d));
          if (exp_i) check($sformatf("i_rdata[%0d]", k), i_rdata[k], rd(k, m_addr[k]));
          if (exp_d && m_wstrb[k] == 4'd0) check($sformatf("d_rdata[%0d]", k), d_rdata[k], rd(k, m_addr[k]));
`ifdef MEM_ARB_STATS_EN
          check($sformatf("stat_gnt_i[%0d]", k), st_i[k], 32'(m_si[k]));
          check($sformatf("stat_gnt_d[%0d]", k), st_d[k], 32'(m_sd[k]));
          check($sformatf("stat_conflict[%0d]", k), st_c[k], 32'(m_sc[k]));
`endif
        end
        hs_i[k] = (i_ready[k] === 1'b1);
        hs_d[k] = (d_ready[k] === 1'b1);
        if (i_ready[k] === 1'b1) begin
          obs[k].push_back(1); obs_cyc[k].push_back(cyc);
          cap_i_rdata[k] = i_rdata[k]; cap_i_addr[k] = mem_addr[k]; cap_i_wstrb[k] = mem_wstrb[k];
        end
        if (d_ready[k] === 1'b1) begin
          obs[k].push_back(2); obs_cyc[k].push_back(cyc);
          cap_d_addr[k] = mem_addr[k]; cap_d_wdata[k] = mem_wdata[k]; cap_d_wstrb[k] = mem_wstrb[k];
        end
        if (mem_valid[k] === 1'b1 && prev_mv[k] !== 1'b1) vst_cyc[k].push_back(cyc);
        prev_mv[k] = mem_valid[k];
        if (reset[k]) begin
          mv[k] = 1'b1; m_own[k] = 0; m_last[k] = 1;
          m_addr[k] = '0; m_wdata[k] = '0; m_wstrb[k] = '0;
          m_si[k] = 0; m_sd[k] = 0; m_sc[k] = 0;
        end else if (mv[k]) begin
          if (m_own[k] != 0) begin
            if (mem_ready[k] === 1'b1) m_own[k] = 0;
          end else begin
            w = 0;
            if (i_valid[k] && d_valid[k]) begin
              w = (k == 1) ? 2 : ((m_last[k] == 2) ? 1 : 2);
              m_sc[k]++;
            end else if (i_valid[k]) w = 1;
            else if (d_valid[k]) w = 2;
            if (w == 1) begin m_addr[k] = i_addr[k]; m_wstrb[k] = '0; m_si[k]++; end
            if (w == 2) begin
              m_addr[k] = d_addr[k]; m_wdata[k] = d_wdata[k]; m_wstrb[k] = d_wstrb[k]; m_sd[k]++;
            end
            if (w != 0) begin m_own[k] = w; m_last[k] = w; end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic bit quiet();
    for (int k = 0; k < 2; k++)
      if (qi[k].size() != 0 || qd[k].size() != 0 || i_valid[k] || d_valid[k] || mem_valid[k] === 1'b1)
        return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input int budget);
    int c = 0;
    while (c < budget && !quiet()) begin step(1); c++; end
    if (c >= budget) begin
      n_chk++;
      $display("FAIL drain_timeout @cyc %0d: still busy after %0d cycles", cyc, budget);
    end
    step(1);
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 2; k++) begin
      obs[k].delete(); obs_cyc[k].delete(); vst_cyc[k].delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; i_valid[k] = 1'b0; d_valid[k] = 1'b0;
      i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0; d_wstrb[k] = '0;
      mem_ready[k] = 1'b0; mem_rdata[k] = '0;
      wait_c[k] = 1; cnt[k] = 0; spur[k] = 1'b0; hs_i[k] = 1'b0; hs_d[k] = 1'b0;
      mv[k] = 1'b0; m_own[k] = 0; m_last[k] = 1; prev_mv[k] = 1'b0;
    end
    mem[{1'b0, 32'h0000_0100}] = 32'hDEAD_BEEF;
    mem[{1'b0, 32'h0000_2000}] = 32'hAAAA_AAAA;

    step(3);
    reset[0] = 1'b0; reset[1] = 1'b0;
    check("rst_mem_valid", 32'(mem_valid[0]), 32'd0);
    check("rst_mem_addr", mem_addr[0], 32'd0);
    check("rst_mem_wdata", mem_wdata[0], 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb[0]), 32'd0);
    check("rst_i_ready", 32'(i_ready[0]), 32'd0);
    check("rst_d_ready", 32'(d_ready[0]), 32'd0);
    check("rst_fx_mem_valid", 32'(mem_valid[1]), 32'd0);

    // Tie right after reset: data first, icache after the bubble
    clear_logs();
    qi[0].push_back(mk(32'h100, 32'h0, 4'h0));
    qd[0].push_back(mk(32'h2000, 32'h1234_5678, 4'b0011));
    drain(100);
    check("tie_count", 32'(obs[0].size()), 32'd2);
    if (obs[0].size() == 2 && vst_cyc[0].size() == 2) begin
      check("tie_first", 32'(obs[0][0]), 32'd2);
      check("tie_second", 32'(obs[0][1]), 32'd1);
      check("tie_i_after_ready", 32'(vst_cyc[0][1] - obs_cyc[0][0]), 32'd2);
      check("round_trip", 32'(vst_cyc[0][1] - vst_cyc[0][0]), 32'd3);
    end
    check("tie_i_rdata", cap_i_rdata[0], 32'hDEAD_BEEF);
    check("wr_addr", cap_d_addr[0], 32'h2000);
    check("wr_wdata", cap_d_wdata[0], 32'h1234_5678);
    check("wr_wstrb", 32'(cap_d_wstrb[0]), 32'h3);
    check("wr_mem_content", rd(0, 32'h2000), 32'hAAAA_5678);
`ifdef MEM_ARB_STATS_EN
    check("tie_conflict", 32'(st_c[0] >= 32'd1), 32'd1);
`endif

    // Single icache read
    clear_logs();
    qi[0].push_back(mk(32'h100, 32'h0, 4'h0));
    drain(50);
    check("rd_count", 32'(obs[0].size()), 32'd1);
    if (obs[0].size() == 1) check("rd_port", 32'(obs[0][0]), 32'd1);
    check("rd_rdata", cap_i_rdata[0], 32'hDEAD_BEEF);
    check("rd_addr", cap_i_addr[0], 32'h100);
    check("rd_wstrb", 32'(cap_i_wstrb[0]), 32'd0);

    // Round-robin fairness with both ports saturated
    reset[0] = 1'b1; step(1); reset[0] = 1'b0;
    clear_logs();
    for (int j = 0; j < 5; j++) begin
      qi[0].push_back(mk(32'h400 + 32'(4 * j), 32'h0, 4'h0));
      qd[0].push_back(mk(32'h800 + 32'(4 * j), 32'hC0DE_0000 + 32'(j), (j % 2 == 0) ? 4'hF : 4'h0));
    end
    drain(300);
    check("rr_count", 32'(obs[0].size()), 32'd10);
    if (obs[0].size() == 10)
      for (int j = 0; j < 10; j++)
        check($sformatf("rr_order_%0d", j), 32'(obs[0][j]), (j % 2 == 0) ? 32'd2 : 32'd1);
`ifdef MEM_ARB_STATS_EN
    check("rr_stat_i", st_i[0], 32'd5);
    check("rr_stat_d", st_d[0], 32'd5);
`endif

    // Fixed priority: data back-to-back starves icache
    clear_logs();
    for (int j = 0; j < 4; j++) qd[1].push_back(mk(32'h3000 + 32'(4 * j), 32'h0, 4'h0));
    qi[1].push_back(mk(32'h3100, 32'h0, 4'h0));
    drain(200);
    check("fx_count", 32'(obs[1].size()), 32'd5);
    if (obs[1].size() == 5 && vst_cyc[1].size() == 5) begin
      for (int j = 0; j < 5; j++)
        check($sformatf("fx_order_%0d", j), 32'(obs[1][j]), (j < 4) ? 32'd2 : 32'd1);
      check("fx_i_gap", 32'(vst_cyc[1][4] - obs_cyc[1][3]), 32'd2);
    end

    // Spurious memory ready while idle is ignored
    clear_logs();
    spur[0] = 1'b1; spur[1] = 1'b1;
    step(3);
    check("spur_no_ready0", 32'(obs[0].size()), 32'd0);
    check("spur_no_ready1", 32'(obs[1].size()), 32'd0);
    check("spur_idle", 32'(mem_valid[0]), 32'd0);

    // Reset in the middle of an icache grant
    clear_logs();
    wait_c[0] = 8;
    qi[0].push_back(mk(32'h300, 32'h0, 4'h0));
    begin
      int c = 0;
      while (c < 20 && mem_valid[0] !== 1'b1) begin step(1); c++; end
      if (c >= 20) begin
        n_chk++;
        $display("FAIL midrst_grant_timeout @cyc %0d: no grant seen", cyc);
      end
    end
    step(2);
    reset[0] = 1'b1; i_valid[0] = 1'b0; qi[0].delete(); hs_i[0] = 1'b0;
    step(1);
    reset[0] = 1'b0;
    check("midrst_mem_valid", 32'(mem_valid[0]), 32'd0);
    check("midrst_mem_addr", mem_addr[0], 32'd0);
    check("midrst_mem_wstrb", 32'(mem_wstrb[0]), 32'd0);
    check("midrst_i_ready", 32'(i_ready[0]), 32'd0);
    step(3);
    check("midrst_no_pulse", 32'(obs[0].size()), 32'd0);
    wait_c[0] = 1;

    // Recovery after the dropped transaction
    clear_logs();
    qi[0].push_back(mk(32'h100, 32'h0, 4'h0));
    drain(50);
    check("recover_count", 32'(obs[0].size()), 32'd1);
    check("recover_rdata", cap_i_rdata[0], 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
